imem_loader: RTL and testbench
==============================

# imem_loader

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and drives a word-aligned write port into a writable instruction memory. It holds the core stalled until a complete image, terminated by the HALT word 32'h11111111 or by a full memory, has been written.

## Interface
Parameters:
- ADDR_WIDTH, 6: word-index width; memory depth is 2**ADDR_WIDTH words (64).
- HALT_WORD, 32'h11111111: end-of-image marker word. It is itself written to memory.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle memory write strobe.
- wr_addr  output  32  byte address, always word-aligned; word index sits in wr_addr[ADDR_WIDTH+1:2].
- wr_data  output  32  instruction word to write.
- cpu_hold  output  1  high while no valid image is present; the core must not fetch.
- done  output  1  image complete; stays high until the next start.
- full  output  1  load ended at memory depth without seeing HALT_WORD.
- word_count  output  ADDR_WIDTH+1  number of stream words written, excluding fill writes.

## Operation
- States: IDLE, ASSEMBLE, WRITE, FILL (present only with the macro), DONE.
- IDLE: in_ready=0. A start pulse clears byte_idx, word_idx, word_count and full, then moves to ASSEMBLE.
- ASSEMBLE: in_ready=1. Each cycle with in_valid&&in_ready places in_data into byte lane byte_idx (byte 0 goes to [7:0]) and increments byte_idx. Acceptance of the 4th byte moves to WRITE.
- WRITE: in_ready=0, wr_en=1, wr_addr={word_idx,2'b00}, wr_data=packed word. word_idx and word_count increment.
  - If the word equals HALT_WORD, go to FILL or DONE.
  - Else if word_idx was 2**ADDR_WIDTH-1, set full=1 and go to FILL or DONE.
  - Otherwise return to ASSEMBLE with byte_idx=0.
- FILL: writes 32'd0 to each remaining index, one per cycle, with wr_en=1, until the last index is written. Then go to DONE. If the image is already full, FILL lasts zero cycles and the FSM goes straight to DONE.
- DONE: done=1, cpu_hold=0, in_ready=0. A start pulse begins a new load: cpu_hold goes back to 1 and done to 0.
- start outside IDLE/DONE is ignored. in_valid while in_ready=0 is neither consumed nor lost; the source holds it.
- A HALT_WORD that lands at the last index sets full=0 (HALT wins).

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, full=0, word_count=0. State resets to IDLE.
- Reset asserted mid-load discards the partial word; writes already issued are not undone.
- All outputs are registered, except in_ready, which is decoded from state.
- Throughput: 4 accepted bytes followed by 1 WRITE cycle, so 5 cycles per word at full rate.
- start to in_ready=1: 1 cycle.
- From the 4th byte of HALT_WORD to done=1:
  - without fill: 2 cycles;
  - with fill: 2 + (2**ADDR_WIDTH − word_count) cycles.

## Configuration
- IMEM_LOADER_ZERO_FILL_EN defined: the FILL state exists, and every unloaded word is written to 32'd0 before done asserts.
- Not defined: FILL is compiled out. WRITE goes directly to DONE, and memory beyond the image keeps its prior contents.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, ASSEMBLE, WRITE, FILL, DONE);
  - the HALT_WORD default constant (32'h11111111);
  - the instruction-word width constant (32).
- One natural sub-module, imem_byte_packer: a byte_idx counter plus a 32-bit lane register. It has a clear input and flags "word ready" on the 4th accepted byte.

## Test plan
- Reset with in_valid=1 → in_ready=0, cpu_hold=1, wr_en never pulses.
- Start, then stream bytes 13,05,c0,00,93,0f,00,00 (hex), then 11,11,11,11 → three writes: addr 0 data 32'h00c00513, addr 4 data 32'h00000f93, addr 8 data 32'h11111111. word_count=3, done=1, full=0, cpu_hold=0.
- Same stream with IMEM_LOADER_ZERO_FILL_EN defined → after the HALT write, 61 zero writes at addr 12..252. done asserts 63 cycles after the HALT 4th byte.
- Stream 256 bytes containing no HALT → 64 writes, last at addr 252, full=1, word_count=64. Further in_valid is not accepted.
- in_valid toggled 1/0 every cycle → words are assembled correctly; no byte is duplicated or dropped.
- Reset asserted after 2 bytes of word 1, then start and a clean stream → word 0 is written at addr 0 from fresh bytes, and word_count restarts at 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader and its byte packer:
// the loader state encoding, the instruction word width and the default
// end-of-image marker word.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD_DEFAULT = 32'h1111_1111;

    // Raw encodings kept as plain constants so older code that compares
    // against bit patterns still lines up with the enum below.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ASSEMBLE = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_FILL     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        ASSEMBLE = ST_ASSEMBLE,
        WRITE    = ST_WRITE,
        FILL     = ST_FILL,
        DONE     = ST_DONE
    } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_byte_packer
// Packs accepted bytes little-endian into a 32-bit word. The first accepted
// byte lands in [7:0]. On the 4th accepted byte word_ready_o is raised and
// word_o already contains that byte, so the caller can capture the complete
// word in the same cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      restart packing at lane 0
//   accept_i     a byte is being accepted this cycle
//   byte_i       byte to place in the current lane
//   word_ready_o 4th byte of a word is being accepted this cycle
//   word_o       stored lanes with the current byte merged in
// ---------------------------------------------------------------------------
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   accept_i,
    input  logic [7:0]             byte_i,
    output logic                   word_ready_o,
    output logic [INSTR_WIDTH-1:0] word_o
);

    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [INSTR_WIDTH-1:0] lanes_q, lanes_d;
    logic [INSTR_WIDTH-1:0] merged;

    // The lane index wraps from 3 to 0 by itself, so a finished word leaves
    // the packer ready for the next one without an explicit clear.
    always_comb begin
        merged = lanes_q;
        merged[{byte_idx_q, 3'b000} +: 8] = byte_i;
        lanes_d    = lanes_q;
        byte_idx_d = byte_idx_q;
        if (clear_i) begin
            lanes_d    = '0;
            byte_idx_d = 2'd0;
        end else if (accept_i) begin
            lanes_d    = merged;
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q <= 2'd0;
            lanes_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
        end
    end

    assign word_ready_o = accept_i && (byte_idx_q == 2'd3);
    assign word_o       = merged;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Takes a byte stream over a
// valid/ready handshake, packs it into 32-bit words and writes them to
// consecutive word addresses. The core is held off until the image ends with
// HALT_WORD (which is itself written) or the memory is full.
//
// Optional feature macro: IMEM_LOADER_ZERO_FILL_EN
//   defined     - after the image, every remaining word is written with zero
//                 before done asserts (FILL state)
//   not defined - loading ends right after the last image word
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      load request pulse, honoured in IDLE or DONE only
//   in_valid   byte stream valid
//   in_data    byte stream data
//   in_ready   a byte is accepted this cycle (decoded from state)
//   wr_en      one-cycle memory write strobe
//   wr_addr    word-aligned byte address of the write
//   wr_data    word to write
//   cpu_hold   core must not fetch
//   done       image complete, held until the next start
//   full       load ended at memory depth without seeing HALT_WORD
//   word_count stream words written (fill writes excluded)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                     ADDR_WIDTH = 6,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [31:0]            wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   full,
    output logic [ADDR_WIDTH:0]    word_count
);

    localparam int                    PAD      = 32 - ADDR_WIDTH - 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  word_idx_q, word_idx_d;
    logic [ADDR_WIDTH:0]    word_count_q, word_count_d;
    logic                   wr_en_q, wr_en_d;
    logic [31:0]            wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   done_q, done_d;
    logic                   full_q, full_d;

    logic                   pack_clear;
    logic                   accept;
    logic                   word_ready;
    logic [INSTR_WIDTH-1:0] packed_word;
    logic [ADDR_WIDTH-1:0]  next_idx;

    function automatic logic [31:0] wordAddr(input logic [ADDR_WIDTH-1:0] idx);
        return {{PAD{1'b0}}, idx, 2'b00};
    endfunction

    assign in_ready = (state_q == ASSEMBLE);
    assign accept   = in_valid && in_ready;
    assign next_idx = word_idx_q + 1'b1;

    imem_byte_packer u_packer (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .clear_i      (pack_clear),
        .accept_i     (accept),
        .byte_i       (in_data),
        .word_ready_o (word_ready),
        .word_o       (packed_word)
    );

    // Every output except in_ready is a register, so the write strobe and
    // its address/data are set up on the transition into WRITE (or FILL)
    // and are visible for exactly the cycle spent in that state.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        full_d       = full_q;
        pack_clear   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pack_clear   = 1'b1;
                    word_idx_d   = '0;
                    word_count_d = '0;
                    full_d       = 1'b0;
                    done_d       = 1'b0;
                    cpu_hold_d   = 1'b1;
                    state_d      = ASSEMBLE;
                end
            end

            ASSEMBLE: begin
                if (word_ready) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wordAddr(word_idx_q);
                    wr_data_d = packed_word;
                    state_d   = WRITE;
                end
            end

            // A HALT word at the last index still counts as a clean end, so
            // full is only raised when the word is not HALT_WORD.
            WRITE: begin
                word_idx_d   = next_idx;
                word_count_d = word_count_q + 1'b1;
                if ((wr_data_q == HALT_WORD) || (word_idx_q == LAST_IDX)) begin
                    full_d = (wr_data_q != HALT_WORD);
`ifdef IMEM_LOADER_ZERO_FILL_EN
                    if (word_idx_q != LAST_IDX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wordAddr(next_idx);
                        wr_data_d = '0;
                        state_d   = FILL;
                    end else begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        state_d    = DONE;
                    end
`else
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = DONE;
`endif
                end else begin
                    state_d = ASSEMBLE;
                end
            end

`ifdef IMEM_LOADER_ZERO_FILL_EN
            // word_idx_q is the index being zeroed this cycle.
            FILL: begin
                word_idx_d = next_idx;
                if (word_idx_q == LAST_IDX) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wordAddr(next_idx);
                    wr_data_d = '0;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            word_count_q <= word_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            full_q       <= full_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign full       = full_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Every word sent is pushed onto a
// scoreboard as the write it should produce (plus the zero writes that follow
// a HALT when IMEM_LOADER_ZERO_FILL_EN is defined); a monitor pops and
// compares on every wr_en strobe.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] HALT  = 32'h1111_1111;
    localparam int          DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        full;
    logic [6:0]  word_count;

    int          totalChecks = 0;
    int          badChecks   = 0;
    int          expIdx      = 0;
    logic [63:0] scoreboard[$];

    imem_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .full       (full),
        .word_count (word_count)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: each strobe must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (scoreboard.size() == 0) begin
                checkOutput("wr_unexpected", wr_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = scoreboard.pop_front();
                checkOutput("wr_addr", wr_addr, e[63:32]);
                checkOutput("wr_data", wr_data, e[31:0]);
            end
        end
    end

    // Offers one byte and returns on the falling edge after it was taken
    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        else @(negedge clk);
    endtask

    // Queues the expected write(s) for one word, then streams it LSB first
    task automatic applyStimulus(input logic [31:0] word, input bit toggle);
        scoreboard.push_back({32'(expIdx * 4), word});
        expIdx++;
`ifdef IMEM_LOADER_ZERO_FILL_EN
        if (word == HALT) begin
            for (int i = expIdx; i < DEPTH; i++)
                scoreboard.push_back({32'(i * 4), 32'h0});
        end
`endif
        for (int k = 0; k < 4; k++) begin
            sendByte(word[k*8 +: 8]);
            if (toggle) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic startLoad();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        expIdx = 0;
        checkOutput("start_ready", 32'(in_ready), 32'd1);
        checkOutput("start_hold", 32'(cpu_hold), 32'd1);
        checkOutput("start_done", 32'(done), 32'd0);
        checkOutput("start_count", 32'(word_count), 32'd0);
    endtask

    // Called right after the final byte; measures falling edges until done
    task automatic waitDone(input int expNeg);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_latency", n, expNeg);
    endtask

    function automatic int haltLatency(input int wc);
`ifdef IMEM_LOADER_ZERO_FILL_EN
        return (wc >= DEPTH) ? 1 : 1 + (DEPTH - wc);
`else
        return 1 + 0 * wc;
`endif
    endfunction

    task automatic checkEnd(input int wc, input bit expFull);
        checkOutput("end_count", 32'(word_count), wc);
        checkOutput("end_full", 32'(full), 32'(expFull));
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_hold", 32'(cpu_hold), 32'd0);
        checkOutput("end_ready", 32'(in_ready), 32'd0);
        checkOutput("sb_empty", scoreboard.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;

        // Reset with the stream already valid
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_count", 32'(word_count), 32'd0);
        checkOutput("rst_wren", 32'(wr_en), 32'd0);
        checkOutput("rst_addr", wr_addr, 32'd0);
        checkOutput("rst_data", wr_data, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_hold", 32'(cpu_hold), 32'd1);

        // Basic image ending in HALT
        $display("[TB] basic image");
        startLoad();
        applyStimulus(32'h00c0_0513, 1'b0);
        applyStimulus(32'h0000_0f93, 1'b0);
        scoreboard.push_back({32'(expIdx * 4), HALT});
        expIdx++;
`ifdef IMEM_LOADER_ZERO_FILL_EN
        for (int i = expIdx; i < DEPTH; i++)
            scoreboard.push_back({32'(i * 4), 32'h0});
`endif
        for (int k = 0; k < 4; k++) sendByte(HALT[k*8 +: 8]);
        in_valid = 1'b0;
        checkOutput("halt_done_early", 32'(done), 32'd0);
        waitDone(haltLatency(3));
        checkEnd(3, 1'b0);

        // Full memory with no HALT
        $display("[TB] full image");
        startLoad();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (w == HALT) w = ~w;
            applyStimulus(w, 1'b0);
        end
        waitDone(1);
        checkEnd(DEPTH, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) @(negedge clk);
        checkOutput("full_no_accept", 32'(in_ready), 32'd0);
        checkOutput("full_count_hold", 32'(word_count), DEPTH);
        in_valid = 1'b0;

        // HALT landing on the last index
        $display("[TB] halt at last index");
        startLoad();
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(32'hA000_0000 + i, 1'b0);
        applyStimulus(HALT, 1'b0);
        waitDone(1);
        checkEnd(DEPTH, 1'b0);

        // Bursty stream, with a start pulse mid-load that must be ignored
        $display("[TB] toggled valid");
        startLoad();
        applyStimulus(32'hDEAD_BEEF, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(32'hCAFE_F00D, 1'b1);
        applyStimulus(HALT, 1'b1);
        waitDone(haltLatency(3) > 1 ? haltLatency(3) - 1 : 0);
        checkEnd(3, 1'b0);

        // Reset in the middle of word 1
        $display("[TB] reset mid-load");
        startLoad();
        applyStimulus(32'h1234_5678, 1'b0);
        sendByte(8'h77);
        sendByte(8'h66);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        checkOutput("midrst_count", 32'(word_count), 32'd0);
        checkOutput("midrst_hold", 32'(cpu_hold), 32'd1);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        startLoad();
        applyStimulus(32'h0BAD_F00D, 1'b0);
        applyStimulus(32'h0000_0013, 1'b0);
        applyStimulus(HALT, 1'b0);
        waitDone(haltLatency(3));
        checkEnd(3, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("sb_final", scoreboard.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
